// File: rtl/writeback_regfile.sv
// writeback_regfile
//   Architectural register file fed by the writeback-stage result, with two
//   combinational operand read ports for decode/issue and a load-pending
//   scoreboard that raises STALL for instructions depending on in-flight loads.
//
// Ports:
//   CLK, RESET_N             clock (rising edge), asynchronous active-low reset
//   WriteData/WriteReg       writeback value and destination index
//   REGWRITE                 writeback valid this cycle
//   ReadReg1/2, ReadData1/2  operand indices and combinational operands
//                            (write-through bypass from the writeback port)
//   ISSUEVALID, ISSUELOAD    instruction presented / instruction is a load
//   IssueDest                destination of the presented instruction
//   STALL                    issue blocked this cycle (combinational)
//   PendingCount             registered number of busy registers
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic              REGWRITE,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              ISSUEVALID,
  input  logic              ISSUELOAD,
  input  logic [ADDR_W-1:0] IssueDest,
  output logic              STALL,
  output logic [CNT_W-1:0]  PendingCount
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;

  logic wr_en;
  logic hazard1, hazard2, hazard_d;
  logic stall_c;
  logic set_en;

  // Writes to index 0 are dropped, so register 0 and busy[0] stay zero.
  assign wr_en = REGWRITE && (WriteReg != '0);

  // Read ports: index 0 reads zero, otherwise a same-cycle writeback wins.
  always_comb begin
    ReadData1 = regs_q[ReadReg1];
    if (ReadReg1 == '0)
      ReadData1 = '0;
    else if (REGWRITE && (WriteReg == ReadReg1))
      ReadData1 = WriteData;

    ReadData2 = regs_q[ReadReg2];
    if (ReadReg2 == '0)
      ReadData2 = '0;
    else if (REGWRITE && (WriteReg == ReadReg2))
      ReadData2 = WriteData;
  end

  // A busy source or load destination only hazards when its writeback is not
  // arriving this very cycle.
  always_comb begin
    hazard1  = (ReadReg1 != '0) && busy_q[ReadReg1] &&
               !(REGWRITE && (WriteReg == ReadReg1));
    hazard2  = (ReadReg2 != '0) && busy_q[ReadReg2] &&
               !(REGWRITE && (WriteReg == ReadReg2));
    hazard_d = ISSUELOAD && (IssueDest != '0) && busy_q[IssueDest] &&
               !(REGWRITE && (WriteReg == IssueDest));
    stall_c  = ISSUEVALID && (hazard1 || hazard2 || hazard_d);
  end

  assign STALL        = stall_c;
  assign PendingCount = pend_cnt_q;

  assign set_en = ISSUEVALID && ISSUELOAD && !stall_c && (IssueDest != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en)
      regs_d[WriteReg] = WriteData;

    // Clear is applied before set so a same-index collision leaves it busy.
    busy_d = busy_q;
    if (wr_en)
      busy_d[WriteReg] = 1'b0;
    if (set_en)
      busy_d[IssueDest] = 1'b1;

    pend_cnt_d = CNT_W'($countones(busy_d));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile
//   Directed bench for writeback_regfile. Expected values are queued as each
//   step is driven and popped when the corresponding DUT output is sampled.
module tb_writeback_regfile;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] WriteData;
  logic [4:0]  WriteReg;
  logic        REGWRITE;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2;
  logic        ISSUEVALID, ISSUELOAD;
  logic [4:0]  IssueDest;
  logic        STALL;
  logic [5:0]  PendingCount;

  writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(6)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .WriteData(WriteData), .WriteReg(WriteReg), .REGWRITE(REGWRITE),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ISSUEVALID(ISSUEVALID), .ISSUELOAD(ISSUELOAD), .IssueDest(IssueDest),
    .STALL(STALL), .PendingCount(PendingCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
    end else begin
      x = q.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    REGWRITE   = 1'b0; WriteReg  = '0; WriteData = '0;
    ISSUEVALID = 1'b0; ISSUELOAD = 1'b0; IssueDest = '0;
    ReadReg1   = '0;   ReadReg2  = '0;
  endtask

  task automatic load(input logic [4:0] dest);
    ISSUEVALID = 1'b1; ISSUELOAD = 1'b1; IssueDest = dest;
  endtask

  initial begin
    RESET_N = 1'b0;
    idle();
    #2;

    // Reset state, and a write attempted while reset is held must not land.
    ReadReg1 = 5'd5;
    #1;
    expect_v("rst_rd1", 32'h0);        check(ReadData1);
    expect_v("rst_stall", 32'h0);      check(32'(STALL));
    expect_v("rst_pcnt", 32'h0);       check(32'(PendingCount));
    REGWRITE = 1'b1; WriteReg = 5'd5; WriteData = 32'hAAAA_5555;
    load(5'd6);
    tick();
    idle();
    ReadReg1 = 5'd5;
    #1;
    expect_v("rst_wr_blocked", 32'h0); check(ReadData1);
    expect_v("rst_set_blocked", 32'h0); check(32'(PendingCount));
    RESET_N = 1'b1;

    // Write then read.
    REGWRITE = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEAD_BEEF;
    tick();
    idle();
    ReadReg1 = 5'd5;
    #1;
    expect_v("wr_rd5", 32'hDEAD_BEEF); check(ReadData1);

    // Bypass on both ports; writes to r0 ignored.
    REGWRITE = 1'b1; WriteReg = 5'd7; WriteData = 32'h0000_1234;
    ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    #1;
    expect_v("byp_rd1", 32'h1234);     check(ReadData1);
    expect_v("byp_rd2", 32'h1234);     check(ReadData2);
    tick();
    REGWRITE = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
    ReadReg1 = 5'd0; ReadReg2 = 5'd7;
    #1;
    expect_v("r0_byp", 32'h0);         check(ReadData1);
    tick();
    idle();
    ReadReg1 = 5'd0; ReadReg2 = 5'd7;
    #1;
    expect_v("r0_rd", 32'h0);          check(ReadData1);
    expect_v("r7_stored", 32'h1234);   check(ReadData2);

    // Load hazard on port 2, resolved by the same-cycle writeback.
    load(5'd3);
    #1;
    expect_v("ld3_nostall", 32'h0);    check(32'(STALL));
    tick();
    idle();
    #1;
    expect_v("ld3_pcnt", 32'd1);       check(32'(PendingCount));
    ISSUEVALID = 1'b1; ReadReg2 = 5'd3;
    #1;
    expect_v("haz2_stall", 32'h1);     check(32'(STALL));
    tick();
    REGWRITE = 1'b1; WriteReg = 5'd3; WriteData = 32'h0000_0333;
    #1;
    expect_v("haz2_resolved", 32'h0);  check(32'(STALL));
    expect_v("haz2_byp", 32'h333);     check(ReadData2);
    tick();
    idle();
    ReadReg2 = 5'd3;
    #1;
    expect_v("wb3_pcnt", 32'd0);       check(32'(PendingCount));
    expect_v("wb3_rd", 32'h333);       check(ReadData2);

    // Hazard on port 1, gated by ISSUEVALID.
    load(5'd4);
    tick();
    idle();
    ReadReg1 = 5'd4; ISSUEVALID = 1'b1;
    #1;
    expect_v("haz1_stall", 32'h1);     check(32'(STALL));
    ISSUEVALID = 1'b0;
    #1;
    expect_v("haz1_novalid", 32'h0);   check(32'(STALL));

    // Set/clear collision on r4: set wins, data still written.
    REGWRITE = 1'b1; WriteReg = 5'd4; WriteData = 32'h0000_4444;
    load(5'd4);
    #1;
    expect_v("coll_nostall", 32'h0);   check(32'(STALL));
    tick();
    idle();
    ReadReg1 = 5'd4;
    #1;
    expect_v("coll_pcnt", 32'd1);      check(32'(PendingCount));
    expect_v("coll_rd4", 32'h4444);    check(ReadData1);
    ISSUEVALID = 1'b1;
    #1;
    expect_v("coll_busy4", 32'h1);     check(32'(STALL));

    // Set and clear on different indices in the same cycle.
    idle();
    REGWRITE = 1'b1; WriteReg = 5'd4; WriteData = 32'h0000_4545;
    load(5'd2);
    tick();
    idle();
    ISSUEVALID = 1'b1; ReadReg1 = 5'd4;
    #1;
    expect_v("diff_pcnt", 32'd1);      check(32'(PendingCount));
    expect_v("diff_clr4", 32'h0);      check(32'(STALL));
    ReadReg2 = 5'd2;
    #1;
    expect_v("diff_set2", 32'h1);      check(32'(STALL));

    // WAW stall on a busy load destination, and loads to r0.
    idle();
    load(5'd9);
    tick();
    idle();
    load(5'd9);
    #1;
    expect_v("waw_stall", 32'h1);      check(32'(STALL));
    expect_v("waw_pcnt_pre", 32'd2);   check(32'(PendingCount));
    tick();
    idle();
    #1;
    expect_v("waw_pcnt", 32'd2);       check(32'(PendingCount));
    load(5'd0);
    #1;
    expect_v("ld0_nostall", 32'h0);    check(32'(STALL));
    tick();
    idle();
    #1;
    expect_v("ld0_pcnt", 32'd2);       check(32'(PendingCount));

    // Build busy = {2,3,9} with reg[2] = 0x55.
    REGWRITE = 1'b1; WriteReg = 5'd2; WriteData = 32'h0000_0055;
    load(5'd3);
    tick();
    idle();
    load(5'd2);
    tick();
    idle();
    ReadReg1 = 5'd2;
    #1;
    expect_v("pre_rst_pcnt", 32'd3);   check(32'(PendingCount));
    expect_v("pre_rst_rd2", 32'h55);   check(ReadData1);

    // Asynchronous reset between edges.
    ISSUEVALID = 1'b1; ReadReg2 = 5'd3;
    #2;
    RESET_N = 1'b0;
    #1;
    expect_v("async_pcnt", 32'd0);     check(32'(PendingCount));
    expect_v("async_rd2", 32'h0);      check(ReadData1);
    expect_v("async_stall", 32'h0);    check(32'(STALL));
    tick();
    RESET_N = 1'b1;
    #1;
    expect_v("post_rst_stall", 32'h0); check(32'(STALL));
    expect_v("post_rst_pcnt", 32'd0);  check(32'(PendingCount));

    if (q.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
